// File: rtl/axi_pkg.sv
// Shared AXI response/burst encodings and FSM state types for the SRAM subordinate.
package axi_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_t;

    function automatic logic burst_unsupported(input logic [1:0] burst);
        return (burst != FIXED) && (burst != INCR);
    endfunction

    function automatic logic [31:0] burst_next_addr(input logic [31:0] addr,
                                                    input logic [2:0]  size,
                                                    input logic [1:0]  burst);
        return (burst == INCR) ? addr + (32'd1 << size) : addr;
    endfunction

endpackage

// File: rtl/axi_sram_array.sv
// Word-organised SRAM with a byte-enable write port and a registered read port;
// a read and write to the same word on one edge returns the pre-write data.
module axi_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 subordinate backed by axi_sram_array, with independent read/write FSMs and
// programmable response latency for stressing the master's handshake logic.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LATENCY  = 2,
    parameter int          WR_LATENCY  = 1,
    parameter int          ID_W        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     awaddr,
    input  logic [ID_W-1:0] awid,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            wvalid,
    output logic            wready,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    output logic            bvalid,
    input  logic            bready,
    output logic [1:0]      bresp,
    output logic [ID_W-1:0] bid,
    input  logic            arvalid,
    output logic            arready,
    input  logic [31:0]     araddr,
    input  logic [ID_W-1:0] arid,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    output logic            rvalid,
    input  logic            rready,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic [ID_W-1:0] rid
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

    function automatic logic in_range(input logic [31:0] a);
        return (a >= ADDR_BASE) && ((a - ADDR_BASE) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - ADDR_BASE) >> 2);
    endfunction

    rd_state_t        rd_state_q, rd_state_d;
    logic [31:0]      rd_addr_q,  rd_addr_d;
    logic [ID_W-1:0]  rd_id_q,    rd_id_d;
    logic [7:0]       rd_len_q,   rd_len_d;
    logic [2:0]       rd_size_q,  rd_size_d;
    logic [1:0]       rd_burst_q, rd_burst_d;
    logic [7:0]       rd_beat_q,  rd_beat_d;
    logic [7:0]       rd_cnt_q,   rd_cnt_d;
    logic             rd_err_q,   rd_err_d;
    logic             rd_sample;
    logic [31:0]      rd_sample_addr;

    wr_state_t        wr_state_q, wr_state_d;
    logic [31:0]      wr_addr_q,  wr_addr_d;
    logic [ID_W-1:0]  wr_id_q,    wr_id_d;
    logic [7:0]       wr_len_q,   wr_len_d;
    logic [2:0]       wr_size_q,  wr_size_d;
    logic [1:0]       wr_burst_q, wr_burst_d;
    logic [7:0]       wr_beat_q,  wr_beat_d;
    logic [7:0]       wr_cnt_q,   wr_cnt_d;
    logic             wr_err_q,   wr_err_d;
    logic             wr_beat_bad;
    logic             wr_is_len;

    logic             arr_we;
    logic [IDX_W-1:0] arr_waddr;
    logic             arr_re;
    logic [IDX_W-1:0] arr_raddr;
    logic [31:0]      arr_rdata;

    axi_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (wdata),
        .wstrb_i (wstrb),
        .re_i    (arr_re),
        .raddr_i (arr_raddr),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_id_q    <= '0;
            rd_len_q   <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= '0;
            rd_beat_q  <= '0;
            rd_cnt_q   <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_id_q    <= rd_id_d;
            rd_len_q   <= rd_len_d;
            rd_size_q  <= rd_size_d;
            rd_burst_q <= rd_burst_d;
            rd_beat_q  <= rd_beat_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // The array is sampled on the edge that leaves R_WAIT and on every non-last
    // R_DATA handshake, so follow-on beats appear the very next cycle.
    always_comb begin
        rd_state_d     = rd_state_q;
        rd_addr_d      = rd_addr_q;
        rd_id_d        = rd_id_q;
        rd_len_d       = rd_len_q;
        rd_size_d      = rd_size_q;
        rd_burst_d     = rd_burst_q;
        rd_beat_d      = rd_beat_q;
        rd_cnt_d       = rd_cnt_q;
        rd_err_d       = rd_err_q;
        rd_sample      = 1'b0;
        rd_sample_addr = rd_addr_q;
        arr_re         = 1'b0;
        arr_raddr      = word_idx(rd_addr_q);

        case (rd_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    rd_addr_d  = araddr;
                    rd_id_d    = arid;
                    rd_len_d   = arlen;
                    rd_size_d  = arsize;
                    rd_burst_d = arburst;
                    rd_beat_d  = '0;
                    rd_cnt_d   = 8'(RD_LATENCY);
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == '0) begin
                    rd_sample  = 1'b1;
                    rd_state_d = R_DATA;
                end else begin
                    rd_cnt_d = rd_cnt_q - 8'd1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rd_beat_q == rd_len_q) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_beat_d      = rd_beat_q + 8'd1;
                        rd_addr_d      = burst_next_addr(rd_addr_q, rd_size_q, rd_burst_q);
                        rd_sample      = 1'b1;
                        rd_sample_addr = rd_addr_d;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        if (rd_sample) begin
            rd_err_d  = !in_range(rd_sample_addr) || burst_unsupported(rd_burst_q);
            arr_re    = !rd_err_d;
            arr_raddr = word_idx(rd_sample_addr);
        end
    end

    assign arready = (rd_state_q == R_IDLE) && !rst;
    assign rvalid  = (rd_state_q == R_DATA) && !rst;
    assign rdata   = (rvalid && !rd_err_q) ? arr_rdata : '0;
    assign rresp   = (rvalid && rd_err_q) ? SLVERR : OKAY;
    assign rlast   = rvalid && (rd_beat_q == rd_len_q);
    assign rid     = rvalid ? rd_id_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_id_q    <= '0;
            wr_len_q   <= '0;
            wr_size_q  <= '0;
            wr_burst_q <= '0;
            wr_beat_q  <= '0;
            wr_cnt_q   <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_id_q    <= wr_id_d;
            wr_len_q   <= wr_len_d;
            wr_size_q  <= wr_size_d;
            wr_burst_q <= wr_burst_d;
            wr_beat_q  <= wr_beat_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // The data phase ends on wlast or on the beat numbered len, whichever comes
    // first; a mismatch between the two is reported as SLVERR.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_addr_d   = wr_addr_q;
        wr_id_d     = wr_id_q;
        wr_len_d    = wr_len_q;
        wr_size_d   = wr_size_q;
        wr_burst_d  = wr_burst_q;
        wr_beat_d   = wr_beat_q;
        wr_cnt_d    = wr_cnt_q;
        wr_err_d    = wr_err_q;
        wr_beat_bad = !in_range(wr_addr_q) || burst_unsupported(wr_burst_q);
        wr_is_len   = (wr_beat_q == wr_len_q);
        arr_we      = 1'b0;
        arr_waddr   = word_idx(wr_addr_q);

        case (wr_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    wr_addr_d  = awaddr;
                    wr_id_d    = awid;
                    wr_len_d   = awlen;
                    wr_size_d  = awsize;
                    wr_burst_d = awburst;
                    wr_beat_d  = '0;
                    wr_err_d   = 1'b0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    arr_we = !wr_beat_bad;
                    if (wr_beat_bad || (wlast != wr_is_len)) begin
                        wr_err_d = 1'b1;
                    end
                    if (wlast || wr_is_len) begin
                        wr_cnt_d   = 8'(WR_LATENCY);
                        wr_state_d = W_WAIT;
                    end else begin
                        wr_beat_d = wr_beat_q + 8'd1;
                        wr_addr_d = burst_next_addr(wr_addr_q, wr_size_q, wr_burst_q);
                    end
                end
            end
            W_WAIT: begin
                if (wr_cnt_q == '0) begin
                    wr_state_d = W_RESP;
                end else begin
                    wr_cnt_d = wr_cnt_q - 8'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign awready = (wr_state_q == W_IDLE) && !rst;
    assign wready  = (wr_state_q == W_DATA) && !rst;
    assign bvalid  = (wr_state_q == W_RESP) && !rst;
    assign bresp   = (bvalid && wr_err_q) ? SLVERR : OKAY;
    assign bid     = bvalid ? wr_id_q : '0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: latency, byte stores, bursts, range errors,
// protocol corners and reset mid-burst, with hand-computed expectations.
module tb_axi_sram_slave;

    logic        clk;
    logic        rst;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_burst [4] = '{32'hA000_0000, 32'hA000_0111, 32'hA000_0222, 32'hA000_0333};

    axi_sram_slave #(
        .ADDR_BASE   (32'h8000_0000),
        .DEPTH_WORDS (1024),
        .RD_LATENCY  (2),
        .WR_LATENCY  (1),
        .ID_W        (4)
    ) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bvalid(output bit timeout);
        int n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        timeout = !bvalid;
    endtask

    task automatic wait_rvalid(output bit timeout);
        int n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        timeout = !rvalid;
    endtask

    task automatic write_single(input logic [31:0] addr, input logic [3:0] id,
                                input logic [31:0] data, input logic [3:0] strb,
                                output logic [1:0] resp, output logic [3:0] id_o,
                                output bit timeout);
        int n = 0;
        awaddr = addr; awid = id; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        while (!awready && n < 20) begin tick(); n++; end
        timeout = !awready;
        tick();
        awvalid = 1'b0;
        wdata = data; wstrb = strb; wlast = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!wready && n < 20) begin tick(); n++; end
        if (!wready) timeout = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        wait_bvalid(timeout);
        resp = bresp; id_o = bid;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic read_single(input logic [31:0] addr, input logic [3:0] id,
                               output logic [31:0] data, output logic [1:0] resp,
                               output logic last, output bit timeout);
        int n = 0;
        araddr = addr; arid = id; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        wait_rvalid(timeout);
        data = rdata; resp = rresp; last = rlast;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b r=%b rdata=%h expected all zero",
                     awready, wready, bvalid, arready, rvalid, rdata);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({awready, arready, wready} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL idle_readies: got aw/ar/w=%b%b%b expected 110", awready, arready, wready);
        end
    endtask

    task automatic test_single_write_read();
        awaddr = 32'h8000_0010; awid = 4'h5; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        checks++;
        if (wready !== 1'b0) begin errors++; $display("[TB] FAIL wready_before_aw: got %b expected 0", wready); end
        tick();
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("[TB] FAIL wready_after_aw: got %b expected 1", wready); end
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        tick();
        checks++;
        if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL bvalid_early: got %b expected 0", bvalid); end
        tick();
        checks++;
        if ({bvalid, bresp, bid} !== {1'b1, 2'b00, 4'h5}) begin
            errors++;
            $display("[TB] FAIL bresp_single: got v=%b resp=%b id=%h expected v=1 resp=00 id=5", bvalid, bresp, bid);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if ({bvalid, awready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL b_release: got bvalid=%b awready=%b expected 0 1", bvalid, awready);
        end

        araddr = 32'h8000_0010; arid = 4'h9; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rvalid_early: got %b expected 0", rvalid); end
        tick();
        checks++;
        if ({rvalid, rdata, rresp, rlast, rid} !== {1'b1, 32'hDEAD_BEEF, 2'b00, 1'b1, 4'h9}) begin
            errors++;
            $display("[TB] FAIL read_single: got v=%b data=%h resp=%b last=%b id=%h expected 1 deadbeef 00 1 9",
                     rvalid, rdata, rresp, rlast, rid);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checks++;
        if ({rvalid, arready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL r_release: got rvalid=%b arready=%b expected 0 1", rvalid, arready);
        end
    endtask

    task automatic test_byte_store();
        logic [1:0] resp; logic [3:0] id_o; logic [31:0] data; logic last; bit to;
        write_single(32'h8000_0010, 4'h1, 32'h1122_3344, 4'hF, resp, id_o, to);
        write_single(32'h8000_0011, 4'h2, 32'h0000_AB00, 4'b0010, resp, id_o, to);
        checks++;
        if ({to, resp, id_o} !== {1'b0, 2'b00, 4'h2}) begin
            errors++;
            $display("[TB] FAIL byte_store_bresp: got to=%b resp=%b id=%h expected 0 00 2", to, resp, id_o);
        end
        read_single(32'h8000_0010, 4'h3, data, resp, last, to);
        checks++;
        if ({to, data, resp} !== {1'b0, 32'h1122_AB44, 2'b00}) begin
            errors++;
            $display("[TB] FAIL byte_store_read: got to=%b data=%h resp=%b expected 0 1122ab44 00", to, data, resp);
        end
    endtask

    task automatic test_incr_burst();
        logic [4:0] pat = 5'b11101;
        int beat = 0;
        bit to;
        awaddr = 32'h8000_0000; awid = 4'h3; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdata = exp_burst[i]; wstrb = 4'hF; wlast = (i == 3); wvalid = 1'b1;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        wait_bvalid(to);
        checks++;
        if ({to, bresp, bid} !== {1'b0, 2'b00, 4'h3}) begin
            errors++;
            $display("[TB] FAIL wburst_bresp: got to=%b resp=%b id=%h expected 0 00 3", to, bresp, bid);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;

        araddr = 32'h8000_0000; arid = 4'h7; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        wait_rvalid(to);
        for (int k = 0; k < 5; k++) begin
            rready = pat[k];
            checks++;
            if ({rvalid, rdata, rlast, rid, rresp} !== {1'b1, exp_burst[beat], (beat == 3), 4'h7, 2'b00}) begin
                errors++;
                $display("[TB] FAIL rburst_beat%0d: got v=%b data=%h last=%b id=%h resp=%b expected 1 %h %b 7 00",
                         beat, rvalid, rdata, rlast, rid, rresp, exp_burst[beat], (beat == 3));
            end
            tick();
            if (pat[k]) beat++;
        end
        rready = 1'b0;
        checks++;
        if ({rvalid, arready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rburst_end: got rvalid=%b arready=%b expected 0 1", rvalid, arready);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [3:0] id_o; logic [31:0] data; logic last; bit to;
        write_single(32'h8000_0FFC, 4'h6, 32'h5A5A_5A5A, 4'hF, resp, id_o, to);
        write_single(32'h7FFF_FFFC, 4'h7, 32'hFFFF_FFFF, 4'hF, resp, id_o, to);
        checks++;
        if ({to, resp, id_o} !== {1'b0, 2'b10, 4'h7}) begin
            errors++;
            $display("[TB] FAIL oor_write_bresp: got to=%b resp=%b id=%h expected 0 10 7", to, resp, id_o);
        end
        read_single(32'h8000_0FFC, 4'h1, data, resp, last, to);
        checks++;
        if ({to, data, resp} !== {1'b0, 32'h5A5A_5A5A, 2'b00}) begin
            errors++;
            $display("[TB] FAIL oor_write_unchanged: got to=%b data=%h resp=%b expected 0 5a5a5a5a 00", to, data, resp);
        end
        read_single(32'h8000_1000, 4'h2, data, resp, last, to);
        checks++;
        if ({to, data, resp, last} !== {1'b0, 32'h0, 2'b10, 1'b1}) begin
            errors++;
            $display("[TB] FAIL oor_read: got to=%b data=%h resp=%b last=%b expected 0 0 10 1", to, data, resp, last);
        end
    endtask

    task automatic test_protocol();
        logic [1:0] resp; logic [31:0] data; logic last; bit to;
        awaddr = 32'h8000_0040; awid = 4'hA; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 32'h1111_1111; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        tick();
        wdata = 32'h2222_2222; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        wait_bvalid(to);
        checks++;
        if ({to, bresp, bid} !== {1'b0, 2'b10, 4'hA}) begin
            errors++;
            $display("[TB] FAIL early_wlast: got to=%b resp=%b id=%h expected 0 10 a", to, bresp, bid);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checks++;
        if ({awready, wready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL early_wlast_idle: got awready=%b wready=%b expected 1 0", awready, wready);
        end

        awaddr = 32'h8000_0060; awid = 4'hB; awlen = 8'd1; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 32'h3333_3333; wlast = 1'b0; wvalid = 1'b1;
        tick();
        tick();
        checks++;
        if (wready !== 1'b0) begin errors++; $display("[TB] FAIL missing_wlast_wready: got %b expected 0", wready); end
        wvalid = 1'b0;
        wait_bvalid(to);
        checks++;
        if ({to, bresp, bid} !== {1'b0, 2'b10, 4'hB}) begin
            errors++;
            $display("[TB] FAIL missing_wlast_bresp: got to=%b resp=%b id=%h expected 0 10 b", to, bresp, bid);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;

        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wready !== 1'b0) begin errors++; $display("[TB] FAIL w_before_aw_%0d: got wready=%b expected 0", i, wready); end
            tick();
        end
        awaddr = 32'h8000_0050; awid = 4'hC; awlen = 8'd0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("[TB] FAIL w_after_aw: got wready=%b expected 1", wready); end
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        wait_bvalid(to);
        checks++;
        if ({to, bresp, bid} !== {1'b0, 2'b00, 4'hC}) begin
            errors++;
            $display("[TB] FAIL w_before_aw_bresp: got to=%b resp=%b id=%h expected 0 00 c", to, bresp, bid);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        read_single(32'h8000_0050, 4'h4, data, resp, last, to);
        checks++;
        if ({to, data, resp} !== {1'b0, 32'hCAFE_F00D, 2'b00}) begin
            errors++;
            $display("[TB] FAIL w_before_aw_read: got to=%b data=%h resp=%b expected 0 cafef00d 00", to, data, resp);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] resp; logic [31:0] data; logic last; bit to;
        araddr = 32'h8000_0000; arid = 4'hD; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        wait_rvalid(to);
        rready = 1'b1;
        tick();
        tick();
        checks++;
        if ({to, rvalid, rdata, rlast} !== {1'b0, 1'b1, 32'hA000_0222, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mid_burst_beat2: got to=%b v=%b data=%h last=%b expected 0 1 a0000222 0",
                     to, rvalid, rdata, rlast);
        end
        rst = 1'b1; rready = 1'b0;
        tick();
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
        rst = 1'b0;
        #1;
        checks++;
        if ({arready, rvalid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got arready=%b rvalid=%b expected 1 0", arready, rvalid);
        end
        read_single(32'h8000_0008, 4'h5, data, resp, last, to);
        checks++;
        if ({to, data, resp} !== {1'b0, 32'hA000_0222, 2'b00}) begin
            errors++;
            $display("[TB] FAIL post_reset_read: got to=%b data=%h resp=%b expected 0 a0000222 00", to, data, resp);
        end
        read_single(32'h8000_0010, 4'h6, data, resp, last, to);
        checks++;
        if ({to, data} !== {1'b0, 32'h1122_AB44}) begin
            errors++;
            $display("[TB] FAIL post_reset_retained: got to=%b data=%h expected 0 1122ab44", to, data);
        end
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
        rready = 1'b0;
        test_reset();
        test_single_write_read();
        test_byte_store();
        test_incr_burst();
        test_out_of_range();
        test_protocol();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
